// File: rtl/serial_paralelo_lane_pkg.sv
// Shared lane constants: comma/idle symbol, idle word and deserializer state encoding.
package serial_paralelo_lane_pkg;

    localparam logic [7:0]  COM_DEFAULT = 8'hBC;
    localparam logic [31:0] IDLE_WORD   = {4{COM_DEFAULT}};

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } lane_state_t;

    function automatic logic [31:0] idle_word(input logic [7:0] com);
        return {4{com}};
    endfunction

endpackage

// File: rtl/serial_paralelo_lane.sv
// Per-lane deserializer: COM-hunt alignment, lock after COM_LOCK aligned COMs, then 32-bit words.
// Zero-cycle latency from last-bit sample to lane_out; no backpressure, each word holds for one word period.
module serial_paralelo_lane
    import serial_paralelo_lane_pkg::*;
#(
    parameter logic [7:0]  COM      = COM_DEFAULT,
    parameter int unsigned COM_LOCK = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_in,
    output logic [31:0] lane_out,
    output logic        valid_out,
    output logic        active
);

    localparam logic [3:0]  LOCK_N = 4'(COM_LOCK);
    localparam logic [31:0] IDLE   = idle_word(COM);

    lane_state_t state, state_nxt;
    // Bit 31 of the logical shift register is never observed once shifted out, so only 31 bits are kept.
    logic [30:0] sh;
    logic [31:0] nxt;
    logic [4:0]  bit_cnt, bit_cnt_nxt;
    logic [3:0]  com_cnt, com_cnt_nxt;
    logic [31:0] lane_nxt;
    logic        valid_nxt;
    logic        byte_is_com;

    assign nxt         = {sh, data_in};
    assign byte_is_com = (nxt[7:0] == COM);

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        com_cnt_nxt = com_cnt;
        lane_nxt    = lane_out;
        valid_nxt   = valid_out;
        case (state)
            SEARCH: begin
                if (byte_is_com) begin
                    bit_cnt_nxt = 5'd0;
                    com_cnt_nxt = 4'd1;
                    state_nxt   = (LOCK_N == 4'd1) ? ACTIVE : COUNT;
                end
            end
            COUNT: begin
                if (bit_cnt == 5'd7) begin
                    bit_cnt_nxt = 5'd0;
                    if (byte_is_com) begin
                        com_cnt_nxt = com_cnt + 4'd1;
                        if (com_cnt + 4'd1 == LOCK_N) begin
                            state_nxt = ACTIVE;
                        end
                    end else begin
                        // Sliding search restarts on the next bit; the failed byte is not rescanned.
                        com_cnt_nxt = 4'd0;
                        state_nxt   = SEARCH;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 5'd1;
                end
            end
            ACTIVE: begin
                bit_cnt_nxt = bit_cnt + 5'd1;
                if (bit_cnt == 5'd31) begin
                    if (nxt == IDLE) begin
                        lane_nxt  = 32'h0;
                        valid_nxt = 1'b0;
                    end else begin
                        lane_nxt  = nxt;
                        valid_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state     <= SEARCH;
            sh        <= '0;
            bit_cnt   <= '0;
            com_cnt   <= '0;
            lane_out  <= 32'h0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_nxt;
            sh        <= nxt[30:0];
            bit_cnt   <= bit_cnt_nxt;
            com_cnt   <= com_cnt_nxt;
            lane_out  <= lane_nxt;
            valid_out <= valid_nxt;
            active    <= (state_nxt == ACTIVE);
        end
    end

endmodule
